// File: rtl/constants_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle ALU.
package constants_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: ADD/SUB/logic/shifts with flag generation.
// MUL is handled by the iterative datapath in alu_mc and yields zero here.
module alu_core
    import constants_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  opcode_e           sel_i,
    input  logic [DWIDTH-1:0] op1_i,
    input  logic [DWIDTH-1:0] op2_i,
    output logic [DWIDTH-1:0] res_o,
    output logic              zero_o,
    output logic              neg_o,
    output logic              carry_o,
    output logic              ovf_o
);

    localparam int SW = $clog2(DWIDTH);

    logic [DWIDTH:0] sum;
    logic [DWIDTH:0] diff;
    logic [SW-1:0]   shamt;

    always_comb begin
        sum     = {1'b0, op1_i} + {1'b0, op2_i};
        // The top bit of diff is the borrow out of the subtraction.
        diff    = {1'b0, op1_i} - {1'b0, op2_i};
        shamt   = op2_i[SW-1:0];
        res_o   = '0;
        carry_o = 1'b0;
        ovf_o   = 1'b0;
        case (sel_i)
            OP_ADD: begin
                res_o   = sum[DWIDTH-1:0];
                carry_o = sum[DWIDTH];
                ovf_o   = (op1_i[DWIDTH-1] == op2_i[DWIDTH-1]) &&
                          (sum[DWIDTH-1] != op1_i[DWIDTH-1]);
            end
            OP_SUB: begin
                res_o   = diff[DWIDTH-1:0];
                carry_o = ~diff[DWIDTH];
                ovf_o   = (op1_i[DWIDTH-1] != op2_i[DWIDTH-1]) &&
                          (diff[DWIDTH-1] != op1_i[DWIDTH-1]);
            end
            OP_AND:  res_o = op1_i & op2_i;
            OP_OR:   res_o = op1_i | op2_i;
            OP_XOR:  res_o = op1_i ^ op2_i;
            OP_SLL:  res_o = op1_i << shamt;
            OP_SRL:  res_o = op1_i >> shamt;
            default: res_o = '0;
        endcase
        zero_o = (res_o == '0);
        neg_o  = res_o[DWIDTH-1];
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops via alu_core,
// MUL via a DWIDTH-step shift-add loop, registered result and flags.
module alu_mc
    import constants_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        sel_i,
    input  logic [DWIDTH-1:0] op1_i,
    input  logic [DWIDTH-1:0] op2_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DWIDTH-1:0] res_o,
    output logic              zero_o,
    output logic              neg_o,
    output logic              carry_o,
    output logic              ovf_o
);

    localparam int            SW       = $clog2(DWIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(DWIDTH - 1);

    opcode_e           sel;
    state_e            state_q, state_d;
    logic [DWIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_step;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] res_q, res_d, core_res;
    logic              zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
    logic              core_zero, core_neg, core_carry, core_ovf;
    logic              accept;

    assign sel = opcode_e'(sel_i);

    alu_core #(.DWIDTH(DWIDTH)) u_core (
        .sel_i   (sel),
        .op1_i   (op1_i),
        .op2_i   (op2_i),
        .res_o   (core_res),
        .zero_o  (core_zero),
        .neg_o   (core_neg),
        .carry_o (core_carry),
        .ovf_o   (core_ovf)
    );

    assign ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
    assign accept   = valid_i && ready_o;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    res_d   = acc_step;
                    zero_d  = (acc_step == '0);
                    neg_d   = acc_step[DWIDTH-1];
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (ready_i) state_d = S_IDLE;
            end
            default: ;
        endcase
        // A new request overrides the DONE->IDLE return, giving back-to-back issue.
        if (accept) begin
            if (sel == OP_MUL) begin
                state_d  = S_BUSY;
                mcand_d  = op1_i;
                mplier_d = op2_i;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                state_d = S_DONE;
                res_d   = core_res;
                zero_d  = core_zero;
                neg_d   = core_neg;
                carry_d = core_carry;
                ovf_d   = core_ovf;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign valid_o = (state_q == S_DONE);
    assign res_o   = res_q;
    assign zero_o  = zero_q;
    assign neg_o   = neg_q;
    assign carry_o = carry_q;
    assign ovf_o   = ovf_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, operand/result width; legal values 4..64.
REQ-002 The block SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port valid_i  input  1  request valid.
REQ-005 The block SHALL have port ready_o  output  1  block can accept request this cycle.
REQ-006 The block SHALL have port sel_i  input  3  opcode: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 MUL=7.
REQ-007 The block SHALL have ports op1_i and op2_i  input  DWIDTH  operands.
REQ-008 The block SHALL have port valid_o  output  1  result valid.
REQ-009 The block SHALL have port ready_i  input  1  consumer accepts result.
REQ-010 The block SHALL have port res_o  output  DWIDTH  registered result.
REQ-011 The block SHALL have ports zero_o, neg_o, carry_o, ovf_o  output  1 each  registered flags.

Function
REQ-012 A request SHALL be accepted on a rising edge where valid_i && ready_o; operands and opcode are captured then.
REQ-013 The FSM SHALL have states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 For opcodes 0..6, IDLE->DONE on accept; valid_o high from the edge after accept (latency 1).
REQ-015 For MUL, IDLE->BUSY on accept; shift-add iteration for exactly DWIDTH edges; BUSY->DONE on the DWIDTH-th edge, so valid_o rises DWIDTH edges after accept.
REQ-016 MUL SHALL produce the low DWIDTH bits of the unsigned product.
REQ-017 SLL/SRL SHALL be logical; shift amount = op2_i[$clog2(DWIDTH)-1:0], upper bits ignored.
REQ-018 ADD/SUB/AND/OR/XOR SHALL wrap modulo 2^DWIDTH.
REQ-019 zero_o SHALL equal (res_o == 0); neg_o SHALL equal res_o[DWIDTH-1]; both for all opcodes.
REQ-020 carry_o SHALL be carry-out for ADD, not-borrow (op1 >= op2 unsigned) for SUB, 0 otherwise.
REQ-021 ovf_o SHALL be signed two's-complement overflow for ADD and SUB, 0 otherwise.
REQ-022 ready_o SHALL be 1 in IDLE, 0 in BUSY, and equal ready_i in DONE (combinational path ready_i->ready_o).
REQ-023 In DONE with ready_i=1 and valid_i=1, result SHALL be consumed and new request accepted on the same edge (back-to-back, 1 op/cycle for non-MUL).
REQ-024 In DONE with ready_i=1 and no new request, state SHALL return to IDLE and valid_o drop on that edge.
REQ-025 While valid_o && !ready_i, res_o and all flags SHALL hold stable.
REQ-026 valid_i and operand changes during BUSY SHALL be ignored.

Reset
REQ-027 rst_ni low SHALL immediately force state IDLE, valid_o=0, res_o=0, zero_o=0, neg_o=0, carry_o=0, ovf_o=0, independent of clk_i.
REQ-028 Reset asserted mid-MUL SHALL abort the operation; no partial result SHALL ever appear on valid_o.
REQ-029 ready_o SHALL be 1 during reset and on the first edge after rst_ni rises.

Structure
REQ-030 constants_pkg SHALL hold the 3-bit opcode enum (extending existing ADD/SUB/AND/OR encodings) and the FSM state enum.
REQ-031 Single-cycle ops SHALL be in one combinational sub-module alu_core (ops 0..6 plus flags); alu_mc holds FSM, multiplier datapath, output registers.

Verification (DWIDTH=8)
REQ-032 ADD 0x7F+0x01, ready_i=1 -> next edge valid_o=1, res_o=0x80, neg_o=1, ovf_o=1, carry_o=0, zero_o=0.
REQ-033 SUB 0x05-0x05 -> res_o=0x00, zero_o=1, carry_o=1, ovf_o=0; then ADD 0xFF+0x01 back-to-back -> res_o=0x00, carry_o=1, one cycle later.
REQ-034 MUL 0x0D*0x0B -> ready_o=0 for 8 cycles, valid_o rises exactly 8 edges after accept, res_o=0x8F, neg_o=1.
REQ-035 SLL 0x81 by op2=0x09 -> res_o=0x02 (amount 1); hold ready_i=0 for 3 cycles -> res_o/flags stable, ready_o=0, valid_o=1.
REQ-036 MUL accepted, rst_ni low at BUSY cycle 3 -> valid_o=0, res_o=0 immediately; after release ready_o=1, no stale result emitted.
